if_id_dump_tx: RTL and testbench
================================

# if_id_dump_tx

Debug-unit serializer that reads the 64-bit IF/ID pipeline latch word and ships it to the host as a framed byte stream through the UART transmitter. On a trigger it snapshots the latch output into a shadow register. It then emits the frame one byte at a time: a header byte, the data bytes MSB first, and an XOR checksum, using a start/done handshake with the UART TX. It sits between the IF/ID latch output and the UART TX inside the debug unit.

## Interface
- `DATA_W`, default 64: width of the captured word; must be a multiple of 8. N = DATA_W/8 data bytes.
- `HEADER`, default 8'hA5: first byte of every frame.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-low reset.
- `i_data`  in  DATA_W: IF/ID latch output ({PC+4, instruction}).
- `i_trigger`  in  1: request a dump; sampled only in IDLE.
- `i_tx_done`  in  1: one-cycle pulse from UART TX when the current byte has finished transmitting.
- `o_tx_start`  out  1: one-cycle pulse that starts transmission of `o_tx_byte`.
- `o_tx_byte`  out  8: byte being sent; held stable from the start pulse until the matching `i_tx_done`.
- `o_busy`  out  1: high while a frame is in progress (SEND, WAIT and DONE states).
- `o_frame_done`  out  1: one-cycle pulse after the last byte completes.

## Operation
- Frame layout, N+2 bytes: HEADER, then data[DATA_W-1:DATA_W-8] down to data[7:0], then CHK.
- CHK = HEADER XOR all N data bytes.
- States:
  - IDLE: on `i_trigger`, shadow <= i_data, chk <= HEADER, idx <= 0, go to SEND; otherwise stay in IDLE.
  - SEND: `o_tx_start`=1 for exactly this cycle; `o_tx_byte` = byte[idx]; go to WAIT.
  - WAIT: hold `o_tx_byte`. On `i_tx_done`:
    - if idx == N+1, go to DONE;
    - otherwise fold data byte[idx] into chk when 1 ≤ idx ≤ N, idx++, go to SEND.
  - DONE: `o_frame_done`=1 for one cycle, then go to IDLE.
- The frame's data comes only from the shadow. Changes on `i_data` after capture do not affect the frame in flight.
- `i_trigger` in SEND, WAIT or DONE is ignored. It is not queued.
- `i_tx_done` outside WAIT is ignored.
- idx width is clog2(N+2). chk is 8 bits; XOR has no carry.

## Timing
- Reset values: state=IDLE, `o_tx_start`=0, `o_tx_byte`=8'h00, `o_busy`=0, `o_frame_done`=0; shadow, chk and idx cleared.
- Reset low mid-frame aborts the frame on the next posedge. No further start pulses are issued.
- Trigger sampled at posedge k:
  - first `o_tx_start` at cycle k+1, with `o_tx_byte`=HEADER;
  - `o_busy` goes high at cycle k+1.
- `i_tx_done` sampled in WAIT at cycle m: next `o_tx_start` at cycle m+1 (two-cycle turnaround per byte).
- Final `i_tx_done` at cycle m: `o_frame_done`=1 at cycle m+1, `o_busy` goes low at cycle m+2.
- The earliest new trigger is accepted at cycle m+2.
- Outputs are registered; no combinational input-to-output path.

## Test plan
- Basic frame: i_data=64'h0000_0004_2001_0005, trigger pulse, TX model returns done 5 cycles after each start -> bytes A5,00,00,00,04,20,01,00,05,85. Exactly 10 start pulses, then one `o_frame_done`.
- All ones: i_data=64'hFFFF_FFFF_FFFF_FFFF -> A5, eight FF bytes, checksum A5.
- Snapshot isolation: change i_data to 64'h1234_5678_9ABC_DEF0 after the header start, and assert i_trigger during WAIT -> frame still carries the original word. No second frame starts.
- Handshake robustness: inject `i_tx_done` in IDLE and in SEND; vary done delay between 1 and 20 cycles -> byte sequence unchanged, and `o_tx_byte` stays stable between each start and its done.
- Reset mid-frame: rst=0 during WAIT of data byte 3 -> next cycle all outputs at reset values. A new trigger afterwards produces a complete correct frame starting with A5.
- Back-to-back frames: trigger held high continuously -> frames separated by exactly the DONE cycle plus the IDLE capture cycle, and each frame re-samples i_data.

Source files
------------

// File: rtl/if_id_dump_tx.sv
// Debug serializer: snapshots the IF/ID latch word and sends it to the UART TX
// as HEADER, data bytes MSB first, then an XOR checksum.
module if_id_dump_tx #(
  parameter int          DATA_W = 64,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_trigger,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  output logic              o_busy,
  output logic              o_frame_done
);
  localparam int N     = DATA_W / 8;
  localparam int IDX_W = $clog2(N + 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [7:0]          chk_q, chk_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          data_byte;

  assign idx_inc = idx_q + IDX_W'(1);

  // Data byte for the next frame position; position k+1 holds shadow byte k from the MSB end.
  always_comb begin
    data_byte = '0;
    for (int k = 0; k < N; k++)
      if (idx_inc == IDX_W'(k + 1)) data_byte = shadow_q[DATA_W-1-8*k -: 8];
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    tx_byte_d    = tx_byte_q;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_trigger) begin
          shadow_d   = i_data;
          chk_d      = HEADER;
          idx_d      = '0;
          tx_byte_d  = HEADER;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == IDX_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            // The byte on the wire is byte[idx]; fold it only for data positions.
            if (idx_q != '0) chk_d = chk_q ^ tx_byte_q;
            idx_d      = idx_inc;
            tx_byte_d  = (idx_inc == IDX_LAST) ? chk_d : data_byte;
            tx_start_d = 1'b1;
            state_d    = S_SEND;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      chk_q        <= '0;
      idx_q        <= '0;
      tx_byte_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      tx_byte_q    <= tx_byte_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
endmodule

// File: tb/tb_if_id_dump_tx.sv
// Bench for if_id_dump_tx: frame-level model with a UART TX responder and
// directed scenarios (basic, all ones, snapshot, handshake, reset, back-to-back).
module tb_if_id_dump_tx;
  localparam int         DATA_W = 64;
  localparam int         N      = DATA_W / 8;
  localparam logic [7:0] HDR    = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_trigger = 1'b0;
  logic              rsp_done = 1'b0;
  logic              inj_done = 1'b0;
  logic              inj_send = 1'b0;
  logic              i_tx_done;
  logic              o_tx_start, o_busy, o_frame_done;
  logic [7:0]        o_tx_byte;

  int  n_checks = 0, n_errors = 0, n_fd = 0, n_start = 0;
  int  tx_delay = 5;
  bit  rnd_delay = 1'b0;
  logic [7:0] log_q[$];

  assign i_tx_done = rsp_done | inj_done;

  always #5 clk = ~clk;

  if_id_dump_tx #(.DATA_W(DATA_W), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_trigger(i_trigger),
    .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t frame_bytes(input logic [DATA_W-1:0] d);
    bq_t q;
    logic [7:0] c, b;
    c = HDR;
    q.push_back(HDR);
    for (int i = N - 1; i >= 0; i--) begin
      b = 8'(d >> (8 * i));
      q.push_back(b);
      c ^= b;
    end
    q.push_back(c);
    return q;
  endfunction

  // Frame-level model: a frame is a queue of bytes; each byte is started one
  // cycle after the trigger or after the previous byte's done.
  bq_t        m_q;
  bit         m_valid = 0, m_active = 0, m_wait = 0, m_start = 0, m_done = 0, m_busy = 0;
  logic [7:0] m_byte = '0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_active = 0; m_wait = 0; m_start = 0; m_done = 0; m_busy = 0; m_byte = '0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_active) begin
      if (i_trigger) begin
        m_q = frame_bytes(i_data);
        m_byte = m_q.pop_front();
        m_start = 1; m_active = 1; m_busy = 1;
      end
    end else if (m_start) begin
      m_start = 0; m_wait = 1;
    end else if (m_wait && i_tx_done) begin
      m_wait = 0;
      if (m_q.size() == 0) begin
        m_active = 0; m_done = 1;
      end else begin
        m_byte = m_q.pop_front();
        m_start = 1;
      end
    end
    m_valid = 1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("tx_start",   64'(o_tx_start),   64'(m_start));
      check("tx_byte",    64'(o_tx_byte),    64'(m_byte));
      check("busy",       64'(o_busy),       64'(m_busy));
      check("frame_done", 64'(o_frame_done), 64'(m_done));
    end
    if (o_frame_done) n_fd++;
    if (o_tx_start) begin
      n_start++;
      log_q.push_back(o_tx_byte);
    end
  end

  // UART TX responder: done pulse d cycles after each start, optional stray done during SEND.
  initial forever begin
    @(negedge clk);
    rsp_done = 1'b0;
    if (o_tx_start) begin
      int d;
      d = rnd_delay ? int'($urandom_range(1, 20)) : tx_delay;
      rsp_done = inj_send;
      for (int i = 1; i < d; i++) begin
        @(negedge clk);
        rsp_done = 1'b0;
      end
      @(negedge clk);
      rsp_done = 1'b1;
    end
  end

  task automatic pulse_trigger(input logic [DATA_W-1:0] d);
    @(negedge clk);
    i_data = d;
    i_trigger = 1'b1;
    @(negedge clk);
    i_trigger = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (n_fd < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(n_fd >= target), 64'(1));
  endtask

  task automatic check_frame(input string name, input logic [DATA_W-1:0] d, input int base);
    bq_t e;
    e = frame_bytes(d);
    check({name, "_len"}, 64'(log_q.size() >= base + N + 2), 64'(1));
    if (log_q.size() >= base + N + 2)
      for (int k = 0; k < N + 2; k++) check(name, 64'(log_q[base + k]), 64'(e[k]));
  endtask

  logic [7:0] e1 [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h20, 8'h01, 8'h00, 8'h05, 8'h85};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, s0;
    bq_t pin;
    logic [DATA_W-1:0] d1, d2, d3;

    repeat (3) @(negedge clk);
    check("rst_start", 64'(o_tx_start), 64'(0));
    check("rst_byte",  64'(o_tx_byte),  64'(0));
    check("rst_busy",  64'(o_busy),     64'(0));
    check("rst_fd",    64'(o_frame_done), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame
    pin = frame_bytes(64'h0000_0004_2001_0005);
    check("model_pin_chk", 64'(pin[9]), 64'h85);
    log_q.delete(); fd0 = n_fd; s0 = n_start; tx_delay = 5;
    pulse_trigger(64'h0000_0004_2001_0005);
    wait_fd(fd0 + 1, 300, "basic_done");
    repeat (5) @(negedge clk);
    check("basic_len", 64'(log_q.size()), 64'(10));
    if (log_q.size() == 10)
      for (int k = 0; k < 10; k++) check("basic_byte", 64'(log_q[k]), 64'(e1[k]));
    check("basic_starts", 64'(n_start - s0), 64'(10));
    check("basic_fd_cnt", 64'(n_fd - fd0), 64'(1));

    // All ones
    log_q.delete(); fd0 = n_fd;
    pulse_trigger(64'hFFFF_FFFF_FFFF_FFFF);
    wait_fd(fd0 + 1, 300, "ones_done");
    repeat (2) @(negedge clk);
    check_frame("ones", 64'hFFFF_FFFF_FFFF_FFFF, 0);
    if (log_q.size() == 10) check("ones_chk", 64'(log_q[9]), 64'hA5);

    // Snapshot isolation and ignored trigger during WAIT
    log_q.delete(); fd0 = n_fd;
    pulse_trigger(64'h0011_2233_4455_6677);
    @(negedge clk);
    i_data = 64'h1234_5678_9ABC_DEF0;
    i_trigger = 1'b1;
    repeat (3) @(negedge clk);
    i_trigger = 1'b0;
    wait_fd(fd0 + 1, 300, "snap_done");
    repeat (30) @(negedge clk);
    check("snap_fd_cnt", 64'(n_fd - fd0), 64'(1));
    check_frame("snap", 64'h0011_2233_4455_6677, 0);
    if (log_q.size() == 10) begin
      check("snap_b2", 64'(log_q[2]), 64'h11);
      check("snap_chk", 64'(log_q[9]), 64'hA5);
    end

    // Handshake robustness: stray done in IDLE and SEND, random delays
    log_q.delete(); fd0 = n_fd;
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    check("idle_done_nostart", 64'(log_q.size()), 64'(0));
    inj_send = 1'b1; rnd_delay = 1'b1;
    pulse_trigger(64'hDEAD_BEEF_0BAD_F00D);
    wait_fd(fd0 + 1, 600, "hs_done");
    repeat (25) @(negedge clk);
    inj_send = 1'b0; rnd_delay = 1'b0;
    check_frame("hs", 64'hDEAD_BEEF_0BAD_F00D, 0);

    // Reset during WAIT of data byte 3
    log_q.delete(); s0 = n_start; tx_delay = 10;
    pulse_trigger(64'h0102_0304_0506_0708);
    for (int i = 0; i < 200 && n_start < s0 + 4; i++) @(negedge clk);
    check("rst_reach_b3", 64'(n_start >= s0 + 4), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_start", 64'(o_tx_start), 64'(0));
    check("midrst_byte",  64'(o_tx_byte),  64'(0));
    check("midrst_busy",  64'(o_busy),     64'(0));
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_nomore", 64'(log_q.size()), 64'(4));
    log_q.delete(); fd0 = n_fd; tx_delay = 3;
    pulse_trigger(64'hCAFE_0000_1111_2222);
    wait_fd(fd0 + 1, 300, "postrst_done");
    repeat (3) @(negedge clk);
    check_frame("postrst", 64'hCAFE_0000_1111_2222, 0);

    // Back-to-back: trigger held high, data changed between frames
    d1 = 64'hAAAA_0000_5555_1234; d2 = 64'h7700_0000_0000_0066; d3 = 64'h0F0F_0F0F_F0F0_F0F0;
    log_q.delete(); fd0 = n_fd; s0 = n_start; tx_delay = 2;
    @(negedge clk);
    i_data = d1; i_trigger = 1'b1;
    for (int i = 0; i < 20 && n_start == s0; i++) @(negedge clk);
    i_data = d2;
    wait_fd(fd0 + 1, 300, "b2b_f1");
    repeat (3) @(negedge clk);
    i_data = d3;
    wait_fd(fd0 + 2, 300, "b2b_f2");
    i_trigger = 1'b0;
    for (int i = 0; i < 300 && o_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b_idle", 64'(o_busy), 64'(0));
    check_frame("b2b_f1", d1, 0);
    check_frame("b2b_f2", d2, 10);
    if (log_q.size() >= 12) begin
      check("b2b_hdr2", 64'(log_q[10]), 64'hA5);
      check("b2b_d2top", 64'(log_q[11]), 64'h77);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
